// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types for the 6502 CPU controller and its address generator.
//   agu_mode_t  - 4-bit addressing-mode codes (ZP=0 ... INDY=8)
//   agu_state_t - sequencing states of cpu_agu
//   agu_decode_mode() - maps raw mode codes to agu_mode_t; codes 9-15 decode as ABS
package cpu_pkg;

  typedef enum logic [3:0] {
    ModeZp   = 4'd0,
    ModeZpx  = 4'd1,
    ModeZpy  = 4'd2,
    ModeAbs  = 4'd3,
    ModeAbsx = 4'd4,
    ModeAbsy = 4'd5,
    ModeInd  = 4'd6,
    ModeIndx = 4'd7,
    ModeIndy = 4'd8
  } agu_mode_t;

  typedef enum logic [2:0] {
    StIdle,
    StOpLo,
    StZpIdx,
    StOpHi,
    StPtrLo,
    StPtrHi,
    StFixup,
    StDone
  } agu_state_t;

  function automatic agu_mode_t agu_decode_mode(input logic [3:0] code);
    return (code > 4'd8) ? ModeAbs : agu_mode_t'(code);
  endfunction

endpackage

// File: rtl/cpu_agu_if.sv
// cpu_agu_if: controller <-> address-generator bundle plus the memory read port.
//   master: CPU controller / memory side (drives start, mode, is_store, x, y, pc, ready, d_in)
//   slave:  cpu_agu (drives addr, pc_inc, busy, ea, ea_valid, page_cross)
interface cpu_agu_if #(
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned AddrW = 2 * DATA_W;

  logic              start;
  logic [3:0]        mode;
  logic              is_store;
  logic [DATA_W-1:0] x;
  logic [DATA_W-1:0] y;
  logic [AddrW-1:0]  pc;
  logic              ready;
  logic [DATA_W-1:0] d_in;
  logic [AddrW-1:0]  addr;
  logic              pc_inc;
  logic              busy;
  logic [AddrW-1:0]  ea;
  logic              ea_valid;
  logic              page_cross;

  modport master (
    output start, mode, is_store, x, y, pc, ready, d_in,
    input  addr, pc_inc, busy, ea, ea_valid, page_cross
  );

  modport slave (
    input  start, mode, is_store, x, y, pc, ready, d_in,
    output addr, pc_inc, busy, ea, ea_valid, page_cross
  );

endinterface

// File: rtl/agu_idx_add.sv
// agu_idx_add: DATA_W-bit adder returning the modulo sum and the carry out of the top bit.
//   a, b  - operands
//   sum   - (a + b) mod 2^DATA_W
//   carry - carry out, i.e. the page-cross indication for index adds
module agu_idx_add #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
  output logic              carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/cpu_agu.sv
// cpu_agu: 6502 effective-address generator. Walks ZP/ABS/indexed/indirect modes one byte
// per cycle over a single-cycle read port, honouring RDY stalls and NMOS page-wrap quirks.
//   clk   - clock, all state on rising edge
//   reset - asynchronous active-low reset; forces IDLE and all outputs to 0
//   bus   - cpu_agu_if.slave: start/mode/is_store/x/y/pc in, ready/d_in memory side,
//           addr/pc_inc/busy out, ea/ea_valid/page_cross result
// Build option: define AGU_PAGE_SKIP_EN to skip FIXUP on indexed reads that do not carry;
// otherwise every ABSX/ABSY/INDY access takes FIXUP.
module cpu_agu
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic      clk,
  input  logic      reset,
  cpu_agu_if.slave  bus
);

  localparam int unsigned AddrW = 2 * DATA_W;
  localparam logic [DATA_W-1:0] ZeroD = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] OneD  = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [AddrW-1:0]  OneA  = {{(AddrW-1){1'b0}}, 1'b1};

`ifdef AGU_PAGE_SKIP_EN
  localparam logic SkipEn = 1'b1;
`else
  localparam logic SkipEn = 1'b0;
`endif

  agu_state_t        state_q;
  agu_mode_t         mode_q;
  logic [AddrW-1:0]  pc_q;
  logic [DATA_W-1:0] x_q, y_q;
  logic [DATA_W-1:0] lo_q, hi_q, ptr_q;
  logic              store_q;
  logic              carry_q;

  logic [DATA_W-1:0] idx;
  logic [DATA_W-1:0] add_a, add_b, add_sum;
  logic              add_carry;
  logic [DATA_W-1:0] ptr_inc;
  logic [AddrW-1:0]  addr_c;
  logic              fix_abs, fix_indy;

  assign idx     = (mode_q == ModeZpy || mode_q == ModeAbsy) ? y_q : x_q;
  assign ptr_inc = ptr_q + OneD;

  // FIXUP is skipped only on carry-free reads, and only when skipping is built in.
  assign fix_abs  = add_carry | store_q | ~SkipEn;
  assign fix_indy = carry_q   | store_q | ~SkipEn;

  // One adder serves ZP_IDX (lo+idx), OP_HI (lo+idx) and PTR_LO (d_in+y).
  always_comb begin
    add_a = lo_q;
    add_b = idx;
    if (state_q == StPtrLo) begin
      add_a = bus.d_in;
      add_b = y_q;
    end
  end

  agu_idx_add #(
    .DATA_W (DATA_W)
  ) u_idx_add (
    .a     (add_a),
    .b     (add_b),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      mode_q  <= ModeZp;
      pc_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      ptr_q   <= '0;
      store_q <= 1'b0;
      carry_q <= 1'b0;
    end else if (bus.ready) begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            pc_q    <= bus.pc;
            x_q     <= bus.x;
            y_q     <= bus.y;
            mode_q  <= agu_decode_mode(bus.mode);
            store_q <= bus.is_store;
            lo_q    <= '0;
            hi_q    <= '0;
            carry_q <= 1'b0;
            state_q <= StOpLo;
          end
        end
        StOpLo: begin
          lo_q  <= bus.d_in;
          // Operand low byte doubles as the pointer for INDY and IND.
          ptr_q <= bus.d_in;
          case (mode_q)
            ModeZp:                      state_q <= StDone;
            ModeZpx, ModeZpy, ModeIndx:  state_q <= StZpIdx;
            ModeIndy:                    state_q <= StPtrLo;
            default:                     state_q <= StOpHi;
          endcase
        end
        StZpIdx: begin
          // Zero-page wrap: the carry is dropped, hi stays 0.
          lo_q    <= add_sum;
          ptr_q   <= add_sum;
          state_q <= (mode_q == ModeIndx) ? StPtrLo : StDone;
        end
        StOpHi: begin
          hi_q <= bus.d_in;
          case (mode_q)
            ModeAbsx, ModeAbsy: begin
              lo_q    <= add_sum;
              carry_q <= add_carry;
              state_q <= fix_abs ? StFixup : StDone;
            end
            ModeInd: state_q <= StPtrLo;
            default: state_q <= StDone;
          endcase
        end
        StPtrLo: begin
          if (mode_q == ModeIndy) begin
            lo_q    <= add_sum;
            carry_q <= add_carry;
          end else begin
            lo_q <= bus.d_in;
          end
          state_q <= StPtrHi;
        end
        StPtrHi: begin
          hi_q    <= bus.d_in;
          state_q <= (mode_q == ModeIndy && fix_indy) ? StFixup : StDone;
        end
        StFixup: begin
          hi_q    <= hi_q + {{(DATA_W-1){1'b0}}, carry_q};
          state_q <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    addr_c = bus.pc;
    unique case (state_q)
      StIdle:  addr_c = bus.pc;
      StOpLo:  addr_c = pc_q;
      StOpHi:  addr_c = pc_q + OneA;
      StZpIdx: addr_c = {ZeroD, lo_q};
      // IND keeps the pointer page in hi; the +1 wraps within that page (NMOS bug).
      StPtrLo: addr_c = (mode_q == ModeInd) ? {hi_q, ptr_q}   : {ZeroD, ptr_q};
      StPtrHi: addr_c = (mode_q == ModeInd) ? {hi_q, ptr_inc} : {ZeroD, ptr_inc};
      StFixup: addr_c = {hi_q, lo_q};
      StDone:  addr_c = {hi_q, lo_q};
      default: addr_c = bus.pc;
    endcase
  end

  // Reset must zero addr too, even though IDLE would otherwise pass pc through.
  assign bus.addr       = reset ? addr_c : '0;
  assign bus.pc_inc     = bus.ready & (state_q == StOpLo || state_q == StOpHi);
  assign bus.busy       = (state_q != StIdle);
  assign bus.ea_valid   = bus.ready & (state_q == StDone);
  assign bus.ea         = bus.ea_valid ? {hi_q, lo_q} : '0;
  assign bus.page_cross = bus.ea_valid & carry_q;

endmodule

// File: tb/tb_cpu_agu.sv
// tb_cpu_agu: scoreboard bench for cpu_agu with a 64 KiB byte memory model on the read port.
module tb_cpu_agu;

  localparam int DW = 8;

`ifdef AGU_PAGE_SKIP_EN
  localparam int LatAbsNc  = 3;
  localparam int LatIndyNc = 4;
`else
  localparam int LatAbsNc  = 4;
  localparam int LatIndyNc = 5;
`endif

  typedef struct {
    logic [15:0] ea;
    logic        pcx;
    int          lat;
    int          pci;
    int          poff;
    logic [15:0] paddr;
    int          start_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  logic [7:0] mem [0:65535];

  cpu_agu_if #(.DATA_W(DW)) bus ();

  cpu_agu #(.DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.d_in = mem[bus.addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: per-cycle probe/pc_inc tracking, pop-and-compare on ea_valid.
  int   off;
  int   pci_cnt = 0;
  exp_t e;
  always @(negedge clk) begin
    if (!reset) pci_cnt = 0;
    else if (sb.size() > 0) begin
      off = cyc - sb[0].start_cyc + 1;
      if (bus.pc_inc) pci_cnt++;
      if (sb[0].poff != 0 && off == sb[0].poff) chk("probe_addr", 32'(bus.addr), 32'(sb[0].paddr));
    end
    if (bus.ea_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ea_valid: got ea 0x%0h with nothing expected", bus.ea);
      end else begin
        e = sb.pop_front();
        chk("ea", 32'(bus.ea), 32'(e.ea));
        chk("page_cross", 32'(bus.page_cross), 32'(e.pcx));
        chk("latency", off, e.lat);
        chk("pc_inc_count", pci_cnt, e.pci);
        pci_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [3:0] m, input logic [7:0] xv, input logic [7:0] yv,
                       input logic [15:0] p, input logic st, input logic [15:0] ea,
                       input logic pcx, input int lat, input int pci, input int poff,
                       input logic [15:0] paddr);
    exp_t it;
    bus.mode     = m;
    bus.x        = xv;
    bus.y        = yv;
    bus.pc       = p;
    bus.is_store = st;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    it.ea = ea; it.pcx = pcx; it.lat = lat; it.pci = pci;
    it.poff = poff; it.paddr = paddr; it.start_cyc = cyc;
    sb.push_back(it);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: %0d results outstanding after 40 cycles", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.mode     = 4'd0;
    bus.is_store = 1'b0;
    bus.x        = 8'h00;
    bus.y        = 8'h00;
    bus.pc       = 16'h1234;
    bus.ready    = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0100] = 8'h44;
    mem[16'h0102] = 8'hF8;
    mem[16'h0104] = 8'h20;
    mem[16'h0110] = 8'h34; mem[16'h0111] = 8'h12;
    mem[16'h0120] = 8'hF0; mem[16'h0121] = 8'h12;
    mem[16'h0130] = 8'h00; mem[16'h0131] = 8'h40;
    mem[16'h0140] = 8'hFF; mem[16'h0141] = 8'h02;
    mem[16'h02FF] = 8'h34; mem[16'h0200] = 8'h12;
    mem[16'h0150] = 8'hFE;
    mem[16'h0003] = 8'h00; mem[16'h0004] = 8'h80;
    mem[16'h0160] = 8'h40;
    mem[16'h0040] = 8'h02; mem[16'h0041] = 8'h30;
    mem[16'h0600] = 8'h78; mem[16'h0601] = 8'h56;

    #3;
    chk("reset_addr", 32'(bus.addr), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    chk("reset_pc_inc", 32'(bus.pc_inc), 32'h0);
    chk("reset_ea_valid", 32'(bus.ea_valid), 32'h0);
    chk("reset_ea", 32'(bus.ea), 32'h0);
    chk("reset_page_cross", 32'(bus.page_cross), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    //    mode   x      y      pc        st    ea        pcx   lat        pci poff paddr
    issue(4'd0, 8'h00, 8'h00, 16'h0100, 1'b0, 16'h0044, 1'b0, 2,         1, 0, 16'h0000); wait_done();
    issue(4'd1, 8'h10, 8'h00, 16'h0102, 1'b0, 16'h0008, 1'b0, 3,         1, 2, 16'h00F8); wait_done();
    issue(4'd2, 8'h00, 8'h03, 16'h0104, 1'b0, 16'h0023, 1'b0, 3,         1, 0, 16'h0000); wait_done();
    issue(4'd3, 8'h00, 8'h00, 16'h0110, 1'b0, 16'h1234, 1'b0, 3,         2, 2, 16'h0111); wait_done();
    issue(4'd4, 8'h20, 8'h00, 16'h0120, 1'b0, 16'h1310, 1'b1, 4,         2, 3, 16'h1210); wait_done();
    issue(4'd4, 8'h01, 8'h00, 16'h0120, 1'b0, 16'h12F1, 1'b0, LatAbsNc,  2, 0, 16'h0000); wait_done();
    issue(4'd4, 8'h01, 8'h00, 16'h0120, 1'b1, 16'h12F1, 1'b0, 4,         2, 3, 16'h12F1); wait_done();
    issue(4'd5, 8'h00, 8'h05, 16'h0130, 1'b0, 16'h4005, 1'b0, LatAbsNc,  2, 0, 16'h0000); wait_done();
    issue(4'd6, 8'h00, 8'h00, 16'h0140, 1'b0, 16'h1234, 1'b0, 5,         2, 4, 16'h0200); wait_done();
    issue(4'd7, 8'h05, 8'h00, 16'h0150, 1'b0, 16'h8000, 1'b0, 5,         1, 3, 16'h0003); wait_done();
    issue(4'd8, 8'h00, 8'hFF, 16'h0160, 1'b0, 16'h3101, 1'b1, 5,         1, 4, 16'h3001); wait_done();
    issue(4'd8, 8'h00, 8'h01, 16'h0160, 1'b0, 16'h3003, 1'b0, LatIndyNc, 1, 0, 16'h0000); wait_done();
    issue(4'd12, 8'h00, 8'h00, 16'h0110, 1'b0, 16'h1234, 1'b0, 3,        2, 0, 16'h0000); wait_done();

    // RDY stall for three cycles while in OP_HI of an ABS access.
    issue(4'd3, 8'h00, 8'h00, 16'h0600, 1'b0, 16'h5678, 1'b0, 6, 2, 0, 16'h0000);
    @(posedge clk); #1;
    bus.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("stall_addr", 32'(bus.addr), 32'h0601);
      chk("stall_pc_inc", 32'(bus.pc_inc), 32'h0);
      chk("stall_ea_valid", 32'(bus.ea_valid), 32'h0);
      @(posedge clk); #1;
    end
    bus.ready = 1'b1;
    wait_done();

    // Reset while an INDY access sits in PTR_LO.
    issue(4'd8, 8'h00, 8'h01, 16'h0160, 1'b0, 16'h3003, 1'b0, LatIndyNc, 1, 0, 16'h0000);
    @(posedge clk); #1;
    chk("pre_reset_ptr_lo_addr", 32'(bus.addr), 32'h0040);
    reset = 1'b0;
    #1;
    sb.delete();
    chk("midrst_addr", 32'(bus.addr), 32'h0);
    chk("midrst_busy", 32'(bus.busy), 32'h0);
    chk("midrst_pc_inc", 32'(bus.pc_inc), 32'h0);
    chk("midrst_ea_valid", 32'(bus.ea_valid), 32'h0);
    chk("midrst_ea", 32'(bus.ea), 32'h0);
    chk("midrst_page_cross", 32'(bus.page_cross), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    issue(4'd0, 8'h00, 8'h00, 16'h0100, 1'b0, 16'h0044, 1'b0, 2, 1, 0, 16'h0000); wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
